// File: rtl/bcd_display_counter_if.sv
// Control/status bundle between the board top and the BCD display counter.
// Latency: none, plain wires grouped for port hygiene.
// Backpressure: none; all signals are level/pulse, no handshake.
interface bcd_display_counter_if #(
    parameter int DIGITS = 4
);
    logic                  run;
    logic                  up;
    logic                  clear;
    logic                  load;
    logic [4*DIGITS-1:0]   load_value;
    logic [4*DIGITS-1:0]   count_bcd;
    logic                  wrap;
    logic [7:0]            segments;
    logic [DIGITS-1:0]     enables;

    // Driver side: the controller producing commands and watching the display pins
    modport master (
        output run, up, clear, load, load_value,
        input  count_bcd, wrap, segments, enables
    );

    // Counter side
    modport slave (
        input  run, up, clear, load, load_value,
        output count_bcd, wrap, segments, enables
    );
endinterface

// File: rtl/bcd_display_counter.sv
// N-digit BCD up/down counter with multiplexed seven-segment driver, single clock domain.
// Latency: count/wrap update on the step/clear/load edge; segments/enables lag count and digit index by 1 cycle.
// Backpressure: none; stepping is gated by a clock-enable prescaler and the run input.
module bcd_display_counter #(
    parameter int DIGITS         = 4,
    parameter int TICK_DIV       = 50000000,
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit EN_ACTIVE_LOW  = 1'b1,
    parameter bit BLANK_LZ       = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    bcd_display_counter_if.slave   bus
);

    localparam int CW     = 4 * DIGITS;
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [7:0]        SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] EN_OFF  = EN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [TICK_W-1:0] tick_q, tick_d;
    logic [SCAN_W-1:0] scan_q, scan_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CW-1:0]     count_q, count_d;
    logic              wrap_q, wrap_d;
    logic [7:0]        seg_q, seg_d;
    logic [DIGITS-1:0] en_q, en_d;

    logic [CW-1:0]     inc_val, dec_val, load_clean;
    logic              carry, borrow;
    logic              step_opp;

    logic [3:0]        cur_dig;
    logic              zero_above, blank_cur;
    logic [6:0]        pattern;
    logic [DIGITS-1:0] en_onehot;

    // Active-high {g,f,e,d,c,b,a} pattern for one BCD digit
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0111111;
            4'd1:    seg7 = 7'b0000110;
            4'd2:    seg7 = 7'b1011011;
            4'd3:    seg7 = 7'b1001111;
            4'd4:    seg7 = 7'b1100110;
            4'd5:    seg7 = 7'b1101101;
            4'd6:    seg7 = 7'b1111101;
            4'd7:    seg7 = 7'b0000111;
            4'd8:    seg7 = 7'b1111111;
            4'd9:    seg7 = 7'b1101111;
            default: seg7 = 7'b0000000;
        endcase
    endfunction

    // Ripple carry/borrow candidates and saturated load value, computed every cycle
    always_comb begin
        inc_val    = count_q;
        dec_val    = count_q;
        load_clean = '0;
        carry      = 1'b1;
        borrow     = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
            if (borrow) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    borrow            = 1'b0;
                end
            end
            // Non-BCD nibbles saturate to 9 so the count never holds an illegal digit
            load_clean[4*i +: 4] = (bus.load_value[4*i +: 4] > 4'd9) ? 4'd9 : bus.load_value[4*i +: 4];
        end
    end

    // Count/tick next state: clear > load > step; the prescaler keeps running while paused
    always_comb begin
        step_opp = (tick_q == TICK_W'(TICK_DIV - 1));
        tick_d   = tick_q;
        count_d  = count_q;
        wrap_d   = 1'b0;
        if (bus.clear) begin
            count_d = '0;
            tick_d  = '0;
        end else if (bus.load) begin
            count_d = load_clean;
            tick_d  = '0;
        end else begin
            tick_d = step_opp ? '0 : tick_q + 1'b1;
            if (step_opp && bus.run) begin
                count_d = bus.up ? inc_val : dec_val;
                wrap_d  = bus.up ? carry : borrow;
            end
        end
    end

    // Scan prescaler and digit index, independent of counting controls
    always_comb begin
        scan_d = (scan_q == SCAN_W'(SCAN_DIV - 1)) ? '0 : scan_q + 1'b1;
        idx_d  = idx_q;
        if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // Digit mux, leading-zero blanking and polarity for the display registers
    always_comb begin
        cur_dig    = 4'd0;
        en_onehot  = '0;
        zero_above = 1'b1;
        blank_cur  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_dig      = count_q[4*i +: 4];
                en_onehot[i] = 1'b1;
            end
        end
        // Walk from the top digit down; digit 0 is never blanked
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_above = zero_above & (count_q[4*i +: 4] == 4'd0);
            if (BLANK_LZ && zero_above && (idx_q == IDX_W'(i))) begin
                blank_cur = 1'b1;
            end
        end
        pattern = blank_cur ? 7'b0000000 : seg7(cur_dig);
        seg_d   = SEG_ACTIVE_LOW ? ~{1'b0, pattern} : {1'b0, pattern};
        en_d    = EN_ACTIVE_LOW ? ~en_onehot : en_onehot;
    end

    // Counter state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q  <= '0;
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            tick_q  <= tick_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    // Scan state and registered display outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_q <= '0;
            idx_q  <= '0;
            seg_q  <= SEG_OFF;
            en_q   <= EN_OFF;
        end else begin
            scan_q <= scan_d;
            idx_q  <= idx_d;
            seg_q  <= seg_d;
            en_q   <= en_d;
        end
    end

    assign bus.count_bcd = count_q;
    assign bus.wrap      = wrap_q;
    assign bus.segments  = seg_q;
    assign bus.enables   = en_q;

endmodule

// File: tb/tb_bcd_display_counter.sv
// Bench for bcd_display_counter: two instances (blanking off/on) against an integer reference model.
// Latency: the model predicts every output after each rising edge.
// Backpressure: none; inputs change 1 time unit after the edge.
module tb_bcd_display_counter;

    localparam int D   = 3;
    localparam int TD  = 4;
    localparam int SD  = 2;
    localparam int MOD = 1000;

    localparam logic [6:0] SEG_TBL [0:9] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
    };

    logic clk = 1'b0;
    logic reset, run, up, clear, load;
    logic [4*D-1:0] load_value;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state
    int         m_cnt, m_tick, m_scan, m_idx;
    bit         m_wrap, m_live;
    logic [7:0] m_seg_a, m_seg_b;
    logic [D-1:0] m_en;

    bcd_display_counter_if #(.DIGITS(D)) ifa ();
    bcd_display_counter_if #(.DIGITS(D)) ifb ();

    assign ifa.run = run;   assign ifb.run = run;
    assign ifa.up = up;     assign ifb.up = up;
    assign ifa.clear = clear; assign ifb.clear = clear;
    assign ifa.load = load; assign ifb.load = load;
    assign ifa.load_value = load_value; assign ifb.load_value = load_value;

    bcd_display_counter #(.DIGITS(D), .TICK_DIV(TD), .SCAN_DIV(SD),
        .SEG_ACTIVE_LOW(1'b1), .EN_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b0))
        dut_a (.clk(clk), .reset(reset), .bus(ifa));

    bcd_display_counter #(.DIGITS(D), .TICK_DIV(TD), .SCAN_DIV(SD),
        .SEG_ACTIVE_LOW(1'b1), .EN_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1))
        dut_b (.clk(clk), .reset(reset), .bus(ifb));

    always #5 clk = ~clk;

    function automatic int p10(input int n);
        int r = 1;
        for (int k = 0; k < n; k++) r = r * 10;
        return r;
    endfunction

    function automatic logic [4*D-1:0] to_bcd(input int v);
        logic [4*D-1:0] r = '0;
        for (int k = 0; k < D; k++) r[4*k +: 4] = 4'((v / p10(k)) % 10);
        return r;
    endfunction

    function automatic int clean_load(input logic [4*D-1:0] lv);
        int r = 0;
        int nib;
        for (int k = 0; k < D; k++) begin
            nib = int'(lv[4*k +: 4]);
            r   = r + ((nib > 9) ? 9 : nib) * p10(k);
        end
        return r;
    endfunction

    function automatic logic [7:0] seg_exp(input int v, input int pos, input bit blz);
        logic [6:0] pat;
        if (blz && pos > 0 && v < p10(pos)) pat = 7'b0000000;
        else pat = SEG_TBL[(v / p10(pos)) % 10];
        return ~{1'b0, pat};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance the model by one edge, clock the DUTs, then compare every output
    task automatic cycle();
        bit nw;
        if (reset) begin
            m_cnt = 0; m_tick = 0; m_scan = 0; m_idx = 0;
            m_wrap = 1'b0; m_live = 1'b0;
            m_seg_a = 8'hFF; m_seg_b = 8'hFF; m_en = '1;
        end else begin
            m_seg_a = seg_exp(m_cnt, m_idx, 1'b0);
            m_seg_b = seg_exp(m_cnt, m_idx, 1'b1);
            m_en    = ~(D'(1) << m_idx);
            m_live  = 1'b1;
            nw = 1'b0;
            if (clear) begin
                m_cnt = 0; m_tick = 0;
            end else if (load) begin
                m_cnt = clean_load(load_value); m_tick = 0;
            end else if (m_tick == TD - 1) begin
                m_tick = 0;
                if (run) begin
                    if (up) begin
                        nw = (m_cnt == MOD - 1);
                        m_cnt = (m_cnt + 1) % MOD;
                    end else begin
                        nw = (m_cnt == 0);
                        m_cnt = (m_cnt + MOD - 1) % MOD;
                    end
                end
            end else begin
                m_tick++;
            end
            m_wrap = nw;
            m_scan++;
            if (m_scan == SD) begin
                m_scan = 0;
                m_idx  = (m_idx + 1) % D;
            end
        end
        @(posedge clk);
        #1;
        chk("count_a", 32'(ifa.count_bcd), 32'(to_bcd(m_cnt)));
        chk("count_b", 32'(ifb.count_bcd), 32'(to_bcd(m_cnt)));
        chk("wrap_a", 32'(ifa.wrap), 32'(m_wrap));
        chk("wrap_b", 32'(ifb.wrap), 32'(m_wrap));
        chk("seg_a", 32'(ifa.segments), 32'(m_seg_a));
        chk("seg_blank", 32'(ifb.segments), 32'(m_seg_b));
        chk("en_a", 32'(ifa.enables), 32'(m_en));
        chk("en_b", 32'(ifb.enables), 32'(m_en));
        if (m_live) chk("one_enable", 32'($countones(~ifa.enables)), 32'd1);
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; up = 1'b1; clear = 1'b0; load = 1'b0; load_value = '0;
        m_cnt = 0; m_tick = 0; m_scan = 0; m_idx = 0; m_wrap = 1'b0; m_live = 1'b0;
        m_seg_a = 8'hFF; m_seg_b = 8'hFF; m_en = '1;
        #1;
        repeat (2) cycle();

        // Count up from reset: first step on the TICK_DIV-th edge
        reset = 1'b0; run = 1'b1; up = 1'b1;
        repeat (3) cycle();
        chk("pre_first_step", 32'(ifa.count_bcd), 32'h000);
        cycle();
        chk("first_step", 32'(ifa.count_bcd), 32'h001);
        repeat (4) cycle();
        chk("second_step", 32'(ifa.count_bcd), 32'h002);

        // Load near the top and roll over
        load_value = 12'h998; load = 1'b1;
        cycle();
        load = 1'b0;
        chk("load_998", 32'(ifa.count_bcd), 32'h998);
        repeat (4) cycle();
        chk("to_999", 32'(ifa.count_bcd), 32'h999);
        repeat (4) cycle();
        chk("wrap_up_cnt", 32'(ifa.count_bcd), 32'h000);
        chk("wrap_up_pulse", 32'(ifa.wrap), 32'd1);
        cycle();
        chk("wrap_up_drop", 32'(ifa.wrap), 32'd0);

        // Count down from reset
        reset = 1'b1;
        cycle();
        reset = 1'b0; up = 1'b0;
        repeat (4) cycle();
        chk("wrap_dn_cnt", 32'(ifa.count_bcd), 32'h999);
        chk("wrap_dn_pulse", 32'(ifa.wrap), 32'd1);
        repeat (4) cycle();
        chk("dn_998", 32'(ifa.count_bcd), 32'h998);

        // Saturating load of non-BCD digits
        load_value = 12'hA5F; load = 1'b1;
        cycle();
        load = 1'b0;
        chk("load_sat", 32'(ifa.count_bcd), 32'h959);

        // Clear and load together on a step opportunity
        for (int k = 0; k < TD && m_tick != TD - 1; k++) cycle();
        clear = 1'b1; load = 1'b1; load_value = 12'h456;
        cycle();
        clear = 1'b0; load = 1'b0;
        chk("clear_wins", 32'(ifa.count_bcd), 32'h000);
        chk("clear_no_wrap", 32'(ifa.wrap), 32'd0);

        // Pause across several periods, then resume
        load_value = 12'h321; load = 1'b1;
        cycle();
        load = 1'b0; run = 1'b0;
        repeat (3 * TD) cycle();
        chk("paused_hold", 32'(ifa.count_bcd), 32'h321);
        run = 1'b1; up = 1'b1;
        repeat (TD) cycle();

        // Display scan patterns with the count frozen
        run = 1'b0;
        load_value = 12'h123; load = 1'b1;
        cycle();
        load = 1'b0;
        repeat (4 * D * SD) cycle();
        load_value = 12'h007; load = 1'b1;
        cycle();
        load = 1'b0;
        repeat (4 * D * SD) cycle();
        load_value = 12'h000; load = 1'b1;
        cycle();
        load = 1'b0;
        repeat (4 * D * SD) cycle();

        // Random traffic including occasional resets and edge-value loads
        repeat (1500) begin
            run   = ($urandom_range(0, 3) != 0);
            up    = $urandom_range(0, 1);
            clear = ($urandom_range(0, 63) == 0);
            load  = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 255) == 0);
            case ($urandom_range(0, 3))
                0:       load_value = 12'h999;
                1:       load_value = 12'h000;
                default: load_value = 12'($urandom);
            endcase
            cycle();
        end
        reset = 1'b0; clear = 1'b0; load = 1'b0;
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
